// File: rtl/sd_response_receiver.sv
// SD CMD-line response receiver: waits for a start bit, shifts in a 48/136-bit frame, checks CRC7 and end bit.
// Latency: FINISH appears N+1 cycles after the start-bit cycle (49 / 137); a timeout finishes TIMEOUT+1 edges after arming.
// Backpressure: none; ENABLE is only honoured in IDLE and results hold until the next accepted ENABLE.
//
// Ports:
//   CLK, RESET          rising-edge clock, synchronous active-high reset
//   ENABLE, LONG,       arm request; LONG selects a 136-bit R2 frame, CHECK_CRC enables CRC7 on 48-bit frames
//   CHECK_CRC
//   IN                  CMD line from the card (idles high)
//   RESP                received frame, right-aligned, zero above the frame length
//   BUSY, FINISH        not-idle indicator; one-cycle completion strobe
//   TIMEOUT_ERR,        no start bit seen; CRC7 mismatch; end bit was 0
//   CRC_ERR, END_ERR
module sd_response_receiver #(
    parameter int TIMEOUT = 64
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         ENABLE,
    input  logic         LONG,
    input  logic         CHECK_CRC,
    input  logic         IN,
    output logic [135:0] RESP,
    output logic         BUSY,
    output logic         FINISH,
    output logic         TIMEOUT_ERR,
    output logic         CRC_ERR,
    output logic         END_ERR
);

    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        RECEIVE,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          long_q;
    logic          check_q;
    logic [7:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic [6:0]    crc;
    logic [7:0]    frame_len;

    // CRC7, polynomial x^7 + x^3 + 1, one bit per step
    function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = c[6] ^ b;
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    assign frame_len = long_q ? 8'd136 : 8'd48;
    assign BUSY      = (state != IDLE);
    assign FINISH    = (state == DONE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The completion checks look at the registered counters, so the frame
    // and timeout decisions land one edge after the last sample.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (ENABLE) state_nxt = WAIT_START;
            WAIT_START: begin
                if (to_cnt == TO_MAX) begin
                    state_nxt = DONE;
                end else if (!IN) begin
                    state_nxt = RECEIVE;
                end
            end
            RECEIVE:    if (bit_cnt == frame_len) state_nxt = DONE;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            RESP        <= '0;
            long_q      <= 1'b0;
            check_q     <= 1'b0;
            bit_cnt     <= '0;
            to_cnt      <= '0;
            crc         <= '0;
            TIMEOUT_ERR <= 1'b0;
            CRC_ERR     <= 1'b0;
            END_ERR     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ENABLE) begin
                        long_q      <= LONG;
                        check_q     <= CHECK_CRC;
                        RESP        <= '0;
                        bit_cnt     <= '0;
                        to_cnt      <= '0;
                        crc         <= '0;
                        TIMEOUT_ERR <= 1'b0;
                        CRC_ERR     <= 1'b0;
                        END_ERR     <= 1'b0;
                    end
                end
                WAIT_START: begin
                    if (to_cnt == TO_MAX) begin
                        TIMEOUT_ERR <= 1'b1;
                    end else if (!IN) begin
                        RESP    <= {RESP[134:0], IN};
                        bit_cnt <= 8'd1;
                        crc     <= crc7_step(crc, IN);
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RECEIVE: begin
                    if (bit_cnt == frame_len) begin
                        // Frame is complete and aligned: resolve the status flags
                        // here so they are valid alongside FINISH.
                        END_ERR <= ~RESP[0];
                        CRC_ERR <= ~long_q & check_q & (crc != RESP[7:1]);
                    end else begin
                        RESP    <= {RESP[134:0], IN};
                        bit_cnt <= bit_cnt + 8'd1;
                        // Only the 40 header/payload bits feed the CRC.
                        if (bit_cnt < 8'd40) begin
                            crc <= crc7_step(crc, IN);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_response_receiver.sv
module tb_sd_response_receiver;

    localparam int TIMEOUT = 64;

    logic         CLK;
    logic         RESET;
    logic         ENABLE;
    logic         LONG;
    logic         CHECK_CRC;
    logic         IN;
    logic [135:0] RESP;
    logic         BUSY;
    logic         FINISH;
    logic         TIMEOUT_ERR;
    logic         CRC_ERR;
    logic         END_ERR;

    sd_response_receiver #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .LONG(LONG), .CHECK_CRC(CHECK_CRC),
        .IN(IN), .RESP(RESP), .BUSY(BUSY), .FINISH(FINISH),
        .TIMEOUT_ERR(TIMEOUT_ERR), .CRC_ERR(CRC_ERR), .END_ERR(END_ERR)
    );

    typedef struct {
        logic [135:0] resp;
        logic         to_err;
        logic         crc_err;
        logic         end_err;
        int           fin_edge;
        int           start_edge;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, req, cyc);
        end
    endtask

    // Reference CRC7: remainder of M(x)*x^7 divided by x^7+x^3+1
    function automatic logic [6:0] crc7_of(input logic [39:0] m);
        logic [46:0] v;
        v = {m, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
        return v[6:0];
    endfunction

    function automatic logic [47:0] make_r1(input logic [37:0] body, input bit bad_crc, input bit bad_end);
        logic [39:0] hdr;
        logic [6:0]  c;
        hdr = {2'b01, body};
        c   = crc7_of(hdr);
        if (bad_crc) c = c ^ 7'(1 + $urandom_range(0, 126));
        return {hdr, c, ~bad_end};
    endfunction

    // Monitor: every FINISH must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!RESET && FINISH) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_finish: FINISH=1 at edge %0d, expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("resp", RESP, e.resp);
                check("timeout_err", 136'(TIMEOUT_ERR), 136'(e.to_err));
                check("crc_err", 136'(CRC_ERR), 136'(e.crc_err));
                check("end_err", 136'(END_ERR), 136'(e.end_err));
                check("finish_edge", 136'(cyc), 136'(e.fin_edge));
            end
        end
    end

    // One transaction: arm, idle ones, frame bits MSB first. n==0 means no
    // frame (line held high). rst_at >= 0 pulses RESET when that bit is driven.
    task automatic run(input bit lng, input bit chk, input int idle,
                       input logic [135:0] fr, input int n, input int rst_at);
        exp_t e;
        int   t;
        @(negedge CLK);
        ENABLE = 1'b1; LONG = lng; CHECK_CRC = chk; IN = 1'b1;
        @(negedge CLK);
        t = cyc;
        ENABLE = 1'b0; LONG = 1'($urandom); CHECK_CRC = 1'($urandom);
        check("busy_after_enable", 136'(BUSY), 136'(1));
        if (idle >= TIMEOUT || n == 0) begin
            e.resp = '0; e.to_err = 1'b1; e.crc_err = 1'b0; e.end_err = 1'b0;
            e.start_edge = -1; e.fin_edge = t + TIMEOUT + 1;
        end else begin
            e.resp       = fr;
            e.to_err     = 1'b0;
            e.end_err    = ~fr[0];
            e.crc_err    = (!lng && chk) ? (crc7_of(fr[47:8]) != fr[7:1]) : 1'b0;
            e.start_edge = t + 1 + idle;
            e.fin_edge   = e.start_edge + n;
        end
        if (rst_at < 0) q.push_back(e);
        for (int i = 0; i < idle && i < TIMEOUT + 3; i++) begin
            IN = 1'b1;
            @(negedge CLK);
        end
        if (idle < TIMEOUT) begin
            for (int j = 0; j < n; j++) begin
                IN = fr[n-1-j];
                if (j == rst_at) begin
                    RESET = 1'b1;
                    @(negedge CLK);
                    RESET = 1'b0;
                    IN    = 1'b1;
                    check("busy_after_reset", 136'(BUSY), 136'(0));
                    check("resp_after_reset", RESP, '0);
                    break;
                end
                @(negedge CLK);
            end
        end
        IN = 1'b1;
        if (rst_at >= 0) repeat (150) @(negedge CLK);
        else repeat (3) @(negedge CLK);
    endtask

    initial begin
        logic [47:0]  f48;
        logic [135:0] f136;
        RESET = 1'b1; ENABLE = 1'b0; LONG = 1'b0; CHECK_CRC = 1'b0; IN = 1'b1;
        repeat (2) @(negedge CLK);
        check("reset_resp", RESP, '0);
        check("reset_busy", 136'(BUSY), 136'(0));
        check("reset_finish", 136'(FINISH), 136'(0));
        check("reset_flags", 136'({TIMEOUT_ERR, CRC_ERR, END_ERR}), 136'(0));
        RESET = 1'b0;
        @(negedge CLK);

        // Directed cases
        f48 = 48'h08000001AA13;
        run(1'b0, 1'b1, 5, 136'(f48), 48, -1);
        f48 = 48'h08000001AA15;
        run(1'b0, 1'b1, 5, 136'(f48), 48, -1);
        f48 = 48'h3F80FF8000FF;
        run(1'b0, 1'b0, 3, 136'(f48), 48, -1);
        run(1'b0, 1'b1, TIMEOUT, '0, 0, -1);
        f48 = 48'h08000001AA13;
        run(1'b0, 1'b1, TIMEOUT - 1, 136'(f48), 48, -1);
        f136 = {$urandom, $urandom, $urandom, $urandom, $urandom};
        f136[135] = 1'b0; f136[0] = 1'b0;
        run(1'b1, 1'b1, 2, f136, 136, -1);
        run(1'b1, 1'b1, 2, f136, 136, 70);
        run(1'b0, 1'b1, 0, 136'(f48), 48, -1);

        // Randomized frames
        for (int k = 0; k < 24; k++) begin
            int idle;
            idle = $urandom_range(0, TIMEOUT + 2);
            if ($urandom_range(0, 3) == 0) begin
                f136 = {$urandom, $urandom, $urandom, $urandom, $urandom};
                f136[135] = 1'b0;
                run(1'b1, 1'($urandom), idle, f136, 136, -1);
            end else begin
                f48 = make_r1({6'($urandom), $urandom}, $urandom_range(0, 2) == 0,
                              $urandom_range(0, 3) == 0);
                run(1'b0, 1'($urandom), idle, 136'(f48), 48, -1);
            end
        end

        repeat (5) @(negedge CLK);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL missing_finish: %0d expected responses never finished, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_response_receiver.md
# sd_response_receiver

Receives card responses on the SD CMD line, the counterpart of the SD command sender in the SD host controller. After a command has been sent, it waits a bounded number of clocks for the start bit. It then shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response and checks the CRC7 and end bit. It reports the frame and status to the initialization and read state machines in a single-cycle FINISH strobe.

## Interface
- TIMEOUT, 64: maximum number of CMD samples at 1 before a start bit; must be at least 1.
- CLK  input  1  SD clock. All logic samples on its rising edge; the card drives CMD on the falling edge.
- RESET  input  1  synchronous, active-high reset.
- ENABLE  input  1  arm request. Sampled only in IDLE.
- LONG  input  1  sampled with ENABLE. 1 selects a 136-bit R2 frame; 0 selects a 48-bit frame.
- CHECK_CRC  input  1  sampled with ENABLE. 1 enables the CRC7 check on 48-bit frames. Drive 0 for R3.
- IN  input  1  CMD line from the card. Idles high.
- RESP  output  136  received frame, right-aligned: last bit received is RESP[0]. Bits above the frame length are 0.
- BUSY  output  1  high in every state except IDLE.
- FINISH  output  1  one-cycle strobe at the end of a reception or a timeout.
- TIMEOUT_ERR  output  1  no start bit was seen within TIMEOUT samples.
- CRC_ERR  output  1  CRC7 mismatch. 48-bit frames with CHECK_CRC=1 only.
- END_ERR  output  1  the final bit received was 0.

## Operation
- States: IDLE, WAIT_START, RECEIVE, DONE.
- **IDLE**
  - On ENABLE=1: latch LONG and CHECK_CRC; clear RESP, the CRC register, all error flags, the bit counter and the timeout counter; go to WAIT_START.
- **WAIT_START**
  - IN=0: shift the 0 in as the first bit, set bit count to 1, feed the bit to the CRC, go to RECEIVE.
  - IN=1: increment the timeout counter. When the count reaches TIMEOUT, set TIMEOUT_ERR and go to DONE.
  - A start bit on the TIMEOUT-th sample counts as a start bit, not a timeout.
- **RECEIVE**
  - Each cycle: RESP <= {RESP[134:0], IN}; bit count increments.
  - Frame length N = 136 when LONG is latched, else 48.
  - CRC7 uses polynomial x^7+x^3+1 with the register initialized to 0. It is updated with each of the first 40 received bits (bit counts 0..39).
  - When the N-th bit is sampled, go to DONE.
- **DONE** (one cycle)
  - FINISH=1.
  - END_ERR = ~RESP[0], except on timeout, where END_ERR=0.
  - CRC_ERR = (CRC register != RESP[7:1]) when the frame is 48-bit and CHECK_CRC=1; otherwise 0.
  - Next state is IDLE.
- RESP and all error flags hold their values from DONE until the next accepted ENABLE.
- ENABLE outside IDLE is ignored.
- IN transitions during RECEIVE are not examined beyond shifting, including an R2 transmission bit or a reserved field.
- The counters are wide enough for 136 bits and for TIMEOUT without wrap. The bit counter is 8 bits; the timeout counter is $clog2(TIMEOUT+1) bits.

## Timing
- Reset values: RESP=0, BUSY=0, FINISH=0, TIMEOUT_ERR=0, CRC_ERR=0, END_ERR=0, state IDLE.
- RESET mid-frame returns to IDLE on the next edge. No FINISH is produced.
- ENABLE is accepted at edge t:
  - BUSY=1 from t+1.
  - The first WAIT_START sample of IN is at edge t+1.
- Start bit sampled at edge s:
  - The final bit is sampled at edge s+N-1.
  - FINISH is high during the cycle after edge s+N, for one cycle. The state is IDLE at s+N+1.
  - Latency from start bit to FINISH: 49 cycles for 48-bit frames, 137 for 136-bit frames.
- Timeout: with IN held at 1, FINISH and TIMEOUT_ERR are visible TIMEOUT+1 edges after t.
- ENABLE high in the same cycle as FINISH is ignored. ENABLE is accepted in the following IDLE cycle.

## Test plan
- R7 frame 48'h08000001AA13, driven MSB first after 5 idle bits, with LONG=0 and CHECK_CRC=1:
  - Response: RESP[47:0]=48'h08000001AA13; all error flags 0; FINISH exactly 49 cycles after the start bit.
- The same frame with the last byte changed to 8'h15 -> CRC_ERR=1, END_ERR=0.
- R3 frame 48'h3F80FF8000FF with CHECK_CRC=0 -> CRC_ERR=0, RESP matches.
- IN held at 1 with TIMEOUT=64:
  - TIMEOUT_ERR=1 and FINISH=1, 65 edges after ENABLE; RESP=0.
- Start bit on exactly the 64th sample -> normal reception with TIMEOUT_ERR=0.
- R2 frame: 136 bits with a 0 end bit, LONG=1:
  - Response: END_ERR=1, CRC_ERR=0.
  - FINISH 137 cycles after the start bit.
  - RESET asserted at bit 70 of a repeat frame → no FINISH; BUSY=0.
